seg_digit_scheduler: RTL and testbench
======================================

Name: seg_digit_scheduler

Overview:
Sequences a multi-digit BCD value through a 7-segment glyph decoder, one digit per transaction, and streams the resulting segment bytes (MSD first) to the OLED renderer over a valid/ready interface. Handles leading-zero blanking and decimal-point insertion. It sits between the frequency-counter BCD result register and the SSD1306 glyph/framebuffer writer.

Parameters:
DIGITS, 6, number of BCD digits in bcd_in (2..8)
BLANK_LEADING, 1, 1 = blank leading zeros, 0 = always show all digits

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start_in  input  1  request to render bcd_in; sampled only in IDLE
bcd_in  input  4*DIGITS  digit values; [3:0] = LSD, top nibble = MSD
dp_en_in  input  1  enable decimal point
dp_pos_in  input  3  digit index (0 = LSD) whose dp bit is set
busy_out  output  1  high from start acceptance until done_out cycle inclusive
done_out  output  1  one-cycle pulse after last byte accepted
data_valid_out  output  1  segment byte valid
data_out  output  8  {dp, g, f, e, d, c, b, a}
data_index_out  output  3  digit index of data_out (0 = LSD)
data_ready_in  input  1  downstream accepts byte when high with data_valid_out

Behaviour:
- Reset (async, reset_n low): state IDLE; busy_out, done_out, data_valid_out = 0; data_out = 0x00; data_index_out = 0; internal capture register, digit counter, and leading flag cleared. Reset mid-transfer aborts silently; no done_out.
- FSM states: IDLE, DECODE, EMIT, DONE.
- IDLE: start_in=1 -> capture bcd_in, dp_en_in, dp_pos_in; digit counter = DIGITS-1; leading flag = BLANK_LEADING; busy_out=1; go DECODE. Inputs after capture are ignored until IDLE.
- DECODE (1 cycle): current nibble drives decoder digit_in. Register {dp, seg[6:0]} into data_out and counter into data_index_out. Set data_valid_out=1 and go EMIT.
- Blanking: seg forced to 0 if leading flag=1, nibble=0, counter!=0, and NOT (dp_en and counter<=dp_pos). Any non-blanked digit clears the leading flag. Nibbles 0xA..0xF pass through as hex glyphs and count as nonzero.
- dp bit = dp_en && (counter == dp_pos). dp_pos >= DIGITS never sets dp.
- EMIT: hold data_out/data_index_out stable while data_valid_out=1 && data_ready_in=0. On handshake: if counter==0, then data_valid_out=0 and go DONE; else counter-1, data_valid_out=0, go DECODE.
- DONE (1 cycle): done_out=1, busy_out=1; next cycle IDLE with busy_out=0. A start_in in the DONE cycle is ignored.
- Latency: start accept at cycle T -> first valid at T+2. Per-digit throughput with ready tied high is 2 cycles. A full frame takes 2*DIGITS+1 cycles from start to done_out.
- data_valid_out never drops without a handshake, except on reset.

Decomposition:
- Shared package seg_pkg: typedef state_t {IDLE, DECODE, EMIT, DONE}; constant SEG_BLANK = 8'h00; localparam DP_BIT = 7.
- Sub-module: one instance of decoder_bin_to_7seg (combinational nibble -> {g..a}). Blanking, dp, and sequencing stay in this block.

Test Plan:
- DIGITS=6, BLANK_LEADING=1, bcd=0x001250, dp off, ready=1 -> bytes idx5..0: 0x00, 0x00, 0x06, 0x5B, 0x6D, 0x3F. done_out at start+13.
- bcd=0x000000, dp_en=1, dp_pos=2 -> 0x00, 0x00, 0x00, 0xBF, 0x3F, 0x3F (zeros at and right of dp shown; dp on idx2).
- BLANK_LEADING=0, bcd=0x00070A -> 0x3F, 0x3F, 0x3F, 0x07, 0x3F, 0x77 (hex A glyph).
- Backpressure: ready low for 5 cycles during idx3 -> data_out and data_index_out stable, valid stays high. The sequence resumes with no lost or duplicated byte.
- start_in pulsed while busy, and in the DONE cycle -> ignored; only one done_out per accepted start. Changing bcd_in mid-frame does not alter the output.
- Assert reset_n low while in EMIT at idx3 -> all outputs 0 immediately, no done_out. After release, a new start renders correctly from idx5.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment digit scheduler.
// Imported by the scheduler top and its glyph decoder.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EMIT,
    DONE
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam int         DP_BIT    = 7;

endpackage

// File: rtl/decoder_bin_to_7seg.sv
// Combinational nibble to 7-segment glyph decoder, {g,f,e,d,c,b,a}.
// Values 0xA..0xF map to hex glyphs A b C d E F.
module decoder_bin_to_7seg (
  input  logic [3:0] digit_in,
  output logic [6:0] seg_out
);

  always_comb begin
    seg_out = 7'h00;
    unique case (digit_in)
      4'h0: seg_out = 7'h3F;
      4'h1: seg_out = 7'h06;
      4'h2: seg_out = 7'h5B;
      4'h3: seg_out = 7'h4F;
      4'h4: seg_out = 7'h66;
      4'h5: seg_out = 7'h6D;
      4'h6: seg_out = 7'h7D;
      4'h7: seg_out = 7'h07;
      4'h8: seg_out = 7'h7F;
      4'h9: seg_out = 7'h6F;
      4'hA: seg_out = 7'h77;
      4'hB: seg_out = 7'h7C;
      4'hC: seg_out = 7'h39;
      4'hD: seg_out = 7'h5E;
      4'hE: seg_out = 7'h79;
      4'hF: seg_out = 7'h71;
    endcase
  end

endmodule

// File: rtl/seg_digit_scheduler.sv
// Streams BCD digits MSD first as 7-segment bytes over valid/ready,
// with leading-zero blanking and decimal-point insertion.
module seg_digit_scheduler #(
  parameter int DIGITS        = 6,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_in,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  dp_en_in,
  input  logic [2:0]            dp_pos_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  data_valid_out,
  output logic [7:0]            data_out,
  output logic [2:0]            data_index_out,
  input  logic                  data_ready_in
);

  import seg_pkg::*;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] cap_q, cap_d;
  logic                dpen_q, dpen_d;
  logic [2:0]          dppos_q, dppos_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                lead_q, lead_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic [7:0]          data_q, data_d;
  logic [2:0]          idx_q, idx_d;

  logic [4*DIGITS-1:0] shifted;
  logic [3:0]          nib;
  logic [6:0]          glyph;
  logic                dp_hit;
  logic                protect;
  logic                blank;
  logic [7:0]          seg_byte;

  assign shifted = cap_q >> {cnt_q, 2'b00};
  assign nib     = shifted[3:0];

  decoder_bin_to_7seg u_dec (
    .digit_in (nib),
    .seg_out  (glyph)
  );

  // Zeros at or right of the decimal point are significant.
  assign dp_hit  = dpen_q && (cnt_q == dppos_q);
  assign protect = dpen_q && (cnt_q <= dppos_q);
  assign blank   = lead_q && (nib == 4'd0)
                && (cnt_q != 3'd0) && !protect;

  always_comb begin
    seg_byte         = SEG_BLANK;
    if (!blank)
      seg_byte[6:0]  = glyph;
    seg_byte[DP_BIT] = dp_hit;
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    dpen_d  = dpen_q;
    dppos_d = dppos_q;
    cnt_d   = cnt_q;
    lead_d  = lead_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          cap_d   = bcd_in;
          dpen_d  = dp_en_in;
          dppos_d = dp_pos_in;
          cnt_d   = 3'(DIGITS - 1);
          lead_d  = BLANK_LEADING;
          busy_d  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        data_d  = seg_byte;
        idx_d   = cnt_q;
        valid_d = 1'b1;
        if (!blank)
          lead_d = 1'b0;
        state_d = EMIT;
      end
      EMIT: begin
        if (data_ready_in) begin
          valid_d = 1'b0;
          if (cnt_q == 3'd0) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q - 3'd1;
            state_d = DECODE;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cap_q   <= '0;
      dpen_q  <= 1'b0;
      dppos_q <= 3'd0;
      cnt_q   <= 3'd0;
      lead_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= SEG_BLANK;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      dpen_q  <= dpen_d;
      dppos_q <= dppos_d;
      cnt_q   <= cnt_d;
      lead_q  <= lead_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign data_valid_out = valid_q;
  assign data_out       = data_q;
  assign data_index_out = idx_q;

endmodule

// File: tb/tb_seg_digit_scheduler.sv
// Directed bench for seg_digit_scheduler: two instances, blanking on
// (u_b) and blanking off (u_n), driven from the same stimulus.
module tb_seg_digit_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_in = 1'b0;
  logic [23:0] bcd_in = '0;
  logic        dp_en_in = 1'b0;
  logic [2:0]  dp_pos_in = 3'd0;
  logic        ready = 1'b1;

  logic       b_busy, b_done, b_valid;
  logic [7:0] b_data;
  logic [2:0] b_idx;
  logic       n_busy, n_done, n_valid;
  logic [7:0] n_data;
  logic [2:0] n_idx;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seg_digit_scheduler #(.DIGITS(6), .BLANK_LEADING(1'b1)) u_b (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_in       (start_in),
    .bcd_in         (bcd_in),
    .dp_en_in       (dp_en_in),
    .dp_pos_in      (dp_pos_in),
    .busy_out       (b_busy),
    .done_out       (b_done),
    .data_valid_out (b_valid),
    .data_out       (b_data),
    .data_index_out (b_idx),
    .data_ready_in  (ready)
  );

  seg_digit_scheduler #(.DIGITS(6), .BLANK_LEADING(1'b0)) u_n (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_in       (start_in),
    .bcd_in         (bcd_in),
    .dp_en_in       (dp_en_in),
    .dp_pos_in      (dp_pos_in),
    .busy_out       (n_busy),
    .done_out       (n_done),
    .data_valid_out (n_valid),
    .data_out       (n_data),
    .data_index_out (n_idx),
    .data_ready_in  (ready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic frame(input string tag, input bit sel,
                       input logic [23:0] bcd, input bit dpen,
                       input logic [2:0] dpp, input logic [47:0] exp_b,
                       input int stall_idx, input bit poke,
                       input int exp_done);
    int n = 0;
    int dcyc = -1;
    int dcount = 0;
    int stalls = 5;
    logic [7:0] hd = '0;
    logic [2:0] hi = '0;
    logic v, dn, bz;
    logic [7:0] d;
    logic [2:0] i;
    @(negedge clk);
    bcd_in = bcd; dp_en_in = dpen; dp_pos_in = dpp;
    start_in = 1'b1; ready = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      v  = sel ? n_valid : b_valid;
      d  = sel ? n_data  : b_data;
      i  = sel ? n_idx   : b_idx;
      dn = sel ? n_done  : b_done;
      bz = sel ? n_busy  : b_busy;
      if (c == 1) begin
        start_in = 1'b0;
        chk({tag, " busy"}, 32'(bz), 32'd1);
      end
      if (poke && c == 4) begin
        start_in = 1'b1; bcd_in = 24'h987654; dp_en_in = ~dpen;
      end
      if (poke && c == 5) start_in = 1'b0;
      if (dcyc > 0 && c == dcyc + 1) start_in = 1'b0;
      if (dn) begin
        dcount++;
        if (dcyc < 0) begin
          dcyc = c;
          if (poke) start_in = 1'b1;
        end
      end
      if (v) begin
        if (stall_idx == int'(i) && stalls > 0) begin
          if (stalls == 5) begin
            hd = d; hi = i;
          end else begin
            chk({tag, " hold data"}, 32'(d), 32'(hd));
            chk({tag, " hold idx"}, 32'(i), 32'(hi));
          end
          ready = 1'b0;
          stalls--;
        end else begin
          ready = 1'b1;
          if (n < 6) begin
            chk({tag, " idx"}, 32'(i), 32'(5 - n));
            chk({tag, " byte"}, 32'(d), 32'(exp_b[47 - 8*n -: 8]));
          end
          n++;
        end
      end else begin
        ready = 1'b1;
      end
      if (dcyc > 0 && c == dcyc + 3) break;
    end
    chk({tag, " nbytes"}, 32'(n), 32'd6);
    chk({tag, " done cycle"}, 32'(dcyc), 32'(exp_done));
    chk({tag, " done count"}, 32'(dcount), 32'd1);
    chk({tag, " busy end"}, 32'(sel ? n_busy : b_busy), 32'd0);
    chk({tag, " valid end"}, 32'(sel ? n_valid : b_valid), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(b_busy), 32'd0);
    chk("rst done", 32'(b_done), 32'd0);
    chk("rst valid", 32'(b_valid), 32'd0);
    chk("rst data", 32'(b_data), 32'h00);
    chk("rst idx", 32'(b_idx), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    frame("t1", 1'b0, 24'h001250, 1'b0, 3'd0,
          {8'h00, 8'h00, 8'h06, 8'h5B, 8'h6D, 8'h3F}, -1, 1'b0, 13);
    frame("t2", 1'b0, 24'h000000, 1'b1, 3'd2,
          {8'h00, 8'h00, 8'h00, 8'hBF, 8'h3F, 8'h3F}, -1, 1'b0, 13);
    frame("t3", 1'b1, 24'h00070A, 1'b0, 3'd0,
          {8'h3F, 8'h3F, 8'h3F, 8'h07, 8'h3F, 8'h77}, -1, 1'b0, 13);
    frame("t4", 1'b0, 24'h123456, 1'b1, 3'd7,
          {8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D}, 3, 1'b0, 18);
    frame("t5", 1'b0, 24'h09F800, 1'b1, 3'd0,
          {8'h00, 8'h6F, 8'h71, 8'h7F, 8'h3F, 8'hBF}, -1, 1'b1, 13);

    // Abort mid-frame while idx3 is held in EMIT.
    @(negedge clk);
    bcd_in = 24'h001250; dp_en_in = 1'b0; start_in = 1'b1; ready = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (b_valid && b_idx == 3'd3) begin
        ready = 1'b0;
        break;
      end
      @(negedge clk);
    end
    chk("abort at idx3", 32'(b_idx), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("abort busy", 32'(b_busy), 32'd0);
    chk("abort done", 32'(b_done), 32'd0);
    chk("abort valid", 32'(b_valid), 32'd0);
    chk("abort data", 32'(b_data), 32'h00);
    chk("abort idx", 32'(b_idx), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post abort done", 32'(b_done), 32'd0);
    chk("post abort valid", 32'(b_valid), 32'd0);

    frame("t6", 1'b0, 24'h001250, 1'b0, 3'd0,
          {8'h00, 8'h00, 8'h06, 8'h5B, 8'h6D, 8'h3F}, -1, 1'b0, 13);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
